// File: rtl/math_adder_multiword_seq.sv
// Multi-cycle wide adder/subtractor: one 32-bit Brent-Kung adder time-shared
// across NUM_WORDS slices, LSW first, carry chained through a register.
// Ports: i_clk, i_rst_n (async, active-low); request i_valid/o_ready with
//   i_a, i_b (W bits), i_c (carry-in, ignored on subtract), i_sub (1: A-B);
//   response o_valid/i_ready with o_sum (W bits), o_carry (1 = no borrow on sub).
// Optional: define MATH_ADDER_MULTIWORD_SEQ_OVERFLOW_EN to add o_overflow,
//   the signed two's-complement overflow of the full-width result.

module math_adder_brent_kung_032 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c,
    output logic [31:0] ow_sum,
    output logic        ow_carry
);
    logic [31:0] w_p;
    logic [31:0] w_gp;
    logic [31:0] w_pp;

    always_comb begin
        w_p  = i_a ^ i_b;
        w_pp = w_p;
        w_gp = i_a & i_b;
        // Fold carry-in into bit 0 so every prefix G is a true carry-out.
        w_gp[0] = w_gp[0] | (w_p[0] & i_c);
        // Up-sweep: build spans of 2, 4, 8, 16, 32 bits.
        for (int d = 0; d < 5; d++) begin
            for (int i = (2 << d) - 1; i < 32; i += (2 << d)) begin
                w_gp[i] = w_gp[i] | (w_pp[i] & w_gp[i - (1 << d)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << d)];
            end
        end
        // Down-sweep: fill in the remaining prefixes.
        for (int d = 3; d >= 0; d--) begin
            for (int i = (3 << d) - 1; i < 32; i += (2 << d)) begin
                w_gp[i] = w_gp[i] | (w_pp[i] & w_gp[i - (1 << d)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << d)];
            end
        end
        ow_sum   = w_p ^ {w_gp[30:0], i_c};
        ow_carry = w_gp[31];
    end
endmodule

module math_adder_multiword_seq #(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [32*NUM_WORDS-1:0] i_a,
    input  logic [32*NUM_WORDS-1:0] i_b,
    input  logic                    i_c,
    input  logic                    i_sub,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [32*NUM_WORDS-1:0] o_sum,
    output logic                    o_carry
`ifdef MATH_ADDER_MULTIWORD_SEQ_OVERFLOW_EN
    ,
    output logic                    o_overflow
`endif
);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    if (WORD_W != 32) begin : g_bad_word_w
        $error("WORD_W must be 32 to match the adder instance");
    end
    if (NUM_WORDS < 1) begin : g_bad_num_words
        $error("NUM_WORDS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                           r_state;
    state_t                           w_next;
    logic [NUM_WORDS-1:0][WORD_W-1:0] r_a;
    logic [NUM_WORDS-1:0][WORD_W-1:0] r_b;
    logic [NUM_WORDS-1:0][WORD_W-1:0] r_sum;
    logic [IW-1:0]                    r_idx;
    logic                             r_cy;
    logic                             r_carry;
    logic [WORD_W-1:0]                w_wa;
    logic [WORD_W-1:0]                w_wb;
    logic [WORD_W-1:0]                w_sum;
    logic                             w_cy;
    logic                             w_last;
    logic                             w_acc;

    assign w_wa   = r_a[r_idx];
    assign w_wb   = r_b[r_idx];
    assign w_last = (r_idx == IW'(NUM_WORDS - 1));
    assign w_acc  = i_valid && (r_state == S_IDLE);

    math_adder_brent_kung_032 u_add (
        .i_a      (w_wa),
        .i_b      (w_wb),
        .i_c      (r_cy),
        .ow_sum   (w_sum),
        .ow_carry (w_cy)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Subtract is A + ~B + 1, so the inversion and carry seed happen at capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_acc) begin
            r_a   <= i_a;
            r_b   <= i_sub ? ~i_b : i_b;
            r_cy  <= i_sub | i_c;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[r_idx] <= w_sum;
            r_cy         <= w_cy;
            r_idx        <= r_idx + 1'b1;
            if (w_last) r_carry <= w_cy;
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;

`ifdef MATH_ADDER_MULTIWORD_SEQ_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    // Same-sign operands producing a different-sign result.
    assign w_ovf = (w_wa[WORD_W-1] == w_wb[WORD_W-1])
                && (w_sum[WORD_W-1] != w_wa[WORD_W-1]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_ovf;
        end
    end

    assign o_overflow = r_ovf;
`endif
endmodule

// File: doc/math_adder_multiword_seq.md
Name: math_adder_multiword_seq

Overview:
Multi-cycle wide-operand adder/subtractor sequencer. It time-shares one instance of math_adder_brent_kung_032 across NUM_WORDS 32-bit slices, least-significant word first, chaining the carry through a register. Operands and result use a valid/ready handshake. It sits in the common math library as the wide-add engine for blocks that cannot afford a full-width combinational adder.

Parameters:
- NUM_WORDS, 4, number of 32-bit words per operand (≥1). Total width is W = 32*NUM_WORDS.
- WORD_W, 32, slice width. Fixed at 32 to match the adder instance. Elaboration error if changed.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand request valid.
- o_ready  output  1  block can accept operands.
- i_a  input  W  operand A.
- i_b  input  W  operand B.
- i_c  input  1  carry-in. Ignored when i_sub=1.
- i_sub  input  1  1: compute A−B. 0: compute A+B+i_c.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_sum  output  W  result.
- o_carry  output  1  carry-out of the top word. For subtract, 1 means no borrow.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, o_ready=1, o_valid=0, o_sum=0, o_carry=0.
  - Internal operand registers, word index and carry register all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: capture i_a into a_reg. Capture b_reg = i_sub ? ~i_b : i_b.
  - Set carry_reg = i_sub ? 1 : i_c. Set idx=0. Go to RUN.
  - o_sum and o_carry keep their previous values.
- RUN:
  - o_ready=0.
  - Adder inputs: a_reg word[idx], b_reg word[idx], carry_reg.
  - Each edge: write adder ow_sum into o_sum word[idx]; carry_reg <= ow_carry; idx++.
  - When idx==NUM_WORDS−1 at the edge: o_carry <= ow_carry, o_valid <= 1, go to DONE.
  - RUN therefore lasts exactly NUM_WORDS cycles.
- DONE:
  - o_valid=1. o_sum and o_carry are held stable.
  - On i_ready: o_valid <= 0, go to IDLE.
  - i_valid is ignored here; o_ready=0.
- Latency: o_valid is asserted NUM_WORDS edges after the accepting edge.
  - Minimum initiation interval is NUM_WORDS+2 cycles (accept, NUM_WORDS RUN, DONE handshake, then IDLE).
  - NUM_WORDS=4 gives latency 4 and interval 6.
- Width rules:
  - idx is $clog2(NUM_WORDS) bits, minimum 1 bit.
  - NUM_WORDS=1 is legal: RUN lasts one cycle.
  - Arithmetic is modulo 2^W. The carry chain spans all words exactly as a W-bit adder would.
- Word ordering: word k occupies bits [32k+31:32k]. Word 0 is processed first.
- Reset mid-operation: any state returns immediately to the reset values. A partial o_sum is never flagged valid.
- Simultaneous events: i_valid during RUN/DONE is not accepted and has no effect. The requester must hold it until o_ready.
- The adder instance is the only arithmetic resource. No other full-width adders are permitted.

Optional Feature:
- Macro: MATH_ADDER_MULTIWORD_SEQ_OVERFLOW_EN.
- Defined:
  - Adds output port o_overflow (1 bit), the signed two's-complement overflow of the full-W result.
  - Computed in the final RUN cycle as carry-into-MSB XOR carry-out-of-MSB, using the top word's a/b(processed) MSBs and sum MSB: ovf = (a31==b31)&&(s31!=a31).
  - Registered alongside o_carry. Reset 0. Held in DONE.
- Not defined: the port and its logic are absent.

Test Plan:
- NUM_WORDS=4, A=2^128−1, B=1, i_c=0, i_sub=0 → o_sum=0, o_carry=1. o_valid rises exactly 4 cycles after the accept edge.
- A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, i_c=0 → o_sum=0x...0001_0000_0000, o_carry=0. This verifies the inter-word carry register.
- Subtract, A=5, B=7, i_sub=1, i_c=1 → o_sum=2^128−2, o_carry=0 (borrow). i_c must be shown to be ignored: the result is identical with i_c=0.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid while pulsing i_valid → o_sum/o_carry stable, o_valid=1, o_ready=0, no new accept. i_ready=1 → IDLE next cycle, then an accept succeeds.
- Assert i_rst_n=0 asynchronously during the 2nd RUN cycle → outputs go immediately to the reset values. After release, a new op A=1, B=2 yields 3.
- With MATH_ADDER_MULTIWORD_SEQ_OVERFLOW_EN: A=0x7FFF...FFFF, B=1 → o_overflow=1, o_sum=0x8000...0000. A=1, B=2 → o_overflow=0.
